// File: rtl/tl_phase_sched_if.sv
// Signal bundle between the intersection phase scheduler and its environment.
// The master side supplies the traffic sensors and the pedestrian request.
// The slave side, which is the scheduler, drives the lights, walk and debug phase.
interface tl_phase_sched_if;
  logic       Ta;
  logic       Tb;
  logic       ped_req;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       walk;
  logic [2:0] phase;

  modport master (output Ta, Tb, ped_req, input La, Lb, walk, phase);
  modport slave  (input Ta, Tb, ped_req, output La, Lb, walk, phase);
endinterface

// File: rtl/tl_phase_sched.sv
// Timed phase scheduler for a two-street intersection.
// Each phase (green, yellow, all-red clearance, walk) is timed by a per-state
// cycle counter. Green has a minimum length, and it is cut at a maximum length
// when cross demand is pending.
// Optional feature: define TL_PED_EN to add the pedestrian walk phase (PED).
// Without it, ped_req is ignored, walk stays 0 and the port list is unchanged.
module tl_phase_sched #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 6,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  tl_phase_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,
    PED    = 3'd6
  } state_e;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;

  localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_M1  = CNT_W'(ALL_RED - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         la_q, lb_q;
  logic               walk_q;
  logic [2:0]         phase_q;
  logic               ped_pending;
  logic               green_done_a, green_done_b, at_max;

`ifdef TL_PED_EN
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK - 1);
  logic ped_pending_q, ped_pending_d;
  logic ped_from_ab_q, ped_from_ab_d;
  assign ped_pending = ped_pending_q;
`else
  // Without the walk feature no request is ever pending, and ped_req is absorbed.
  logic unused_ped_req;
  assign unused_ped_req = bus.ped_req;
  assign ped_pending    = 1'b0;
`endif

  // Green exit: the minimum time has been served, and either own traffic is
  // gone or maximum green is reached while the cross street or a pedestrian waits.
  assign at_max       = (cnt_q == MAX_M1);
  assign green_done_a = (cnt_q >= MIN_M1) &&
                        (!bus.Ta || (at_max && (bus.Tb || ped_pending)));
  assign green_done_b = (cnt_q >= MIN_M1) &&
                        (!bus.Tb || (at_max && (bus.Ta || ped_pending)));

  // Next-state, counter and pedestrian bookkeeping.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      A_GRN:  if (green_done_a)      state_d = A_YEL;
      A_YEL:  if (cnt_q == YEL_M1)   state_d = RED_AB;
      RED_AB: if (cnt_q == RED_M1)   state_d = ped_pending ? PED : B_GRN;
      B_GRN:  if (green_done_b)      state_d = B_YEL;
      B_YEL:  if (cnt_q == YEL_M1)   state_d = RED_BA;
      RED_BA: if (cnt_q == RED_M1)   state_d = ped_pending ? PED : A_GRN;
`ifdef TL_PED_EN
      PED:    if (cnt_q == WALK_M1)  state_d = ped_from_ab_q ? B_GRN : A_GRN;
`endif
      default:                       state_d = A_GRN;
    endcase

    // The counter restarts on every state change and saturates so that a long green never wraps.
    if (state_d != state_q)  cnt_d = '0;
    else if (at_max)         cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;

`ifdef TL_PED_EN
    ped_pending_d = ped_pending_q;
    ped_from_ab_d = ped_from_ab_q;
    if (bus.ped_req && state_q != PED) ped_pending_d = 1'b1;
    // Entering the walk consumes the request and remembers which green resumes.
    if (state_d == PED && state_q != PED) begin
      ped_pending_d = 1'b0;
      ped_from_ab_d = (state_q == RED_AB);
    end
`endif
  end

  // State and counter registers, with the outputs decoded from the next state so that they are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= A_GRN;
      cnt_q   <= '0;
      la_q    <= L_GREEN;
      lb_q    <= L_RED;
      walk_q  <= 1'b0;
      phase_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      la_q    <= (state_d == A_GRN) ? L_GREEN : (state_d == A_YEL) ? L_YELLOW : L_RED;
      lb_q    <= (state_d == B_GRN) ? L_GREEN : (state_d == B_YEL) ? L_YELLOW : L_RED;
      walk_q  <= (state_d == PED);
      phase_q <= state_d;
    end
  end

`ifdef TL_PED_EN
  // Pedestrian request latch and walk-origin flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pending_q <= 1'b0;
      ped_from_ab_q <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
      ped_from_ab_q <= ped_from_ab_d;
    end
  end
`endif

  assign bus.La    = la_q;
  assign bus.Lb    = lb_q;
  assign bus.walk  = walk_q;
  assign bus.phase = phase_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Bench for tl_phase_sched: table of timing checkpoints, hand-written corner
// sequences, and randomized traffic checked against a phase/elapsed-time model.
// Covers both builds, with or without TL_PED_EN.
module tb_tl_phase_sched;
  localparam int MIN_GREEN = 8;
  localparam int MAX_GREEN = 32;
  localparam int YELLOW    = 3;
  localparam int ALL_RED   = 1;
  localparam int WALK      = 6;

`ifdef TL_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10;

  logic clk = 1'b0;
  logic reset;
  tl_phase_sched_if bus();

  tl_phase_sched #(
    .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW(YELLOW),
    .ALL_RED(ALL_RED), .WALK(WALK), .CNT_W(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the current phase plus the cycles already spent in it.
  int m_phase, m_el;
  bit m_pend, m_from_ab;

  function automatic logic [7:0] model_out();
    logic [1:0] la, lb;
    la = (m_phase == 0) ? G : (m_phase == 1) ? Y : R;
    lb = (m_phase == 3) ? G : (m_phase == 4) ? Y : R;
    return {la, lb, (m_phase == 6), 3'(m_phase)};
  endfunction

  task automatic model_step(input bit rst, input bit ta, input bit tb, input bit pr);
    int  nxt;
    int  lasted;
    bit  pend;
    if (rst) begin
      m_phase = 0; m_el = 0; m_pend = 0; m_from_ab = 0;
      return;
    end
    nxt    = m_phase;
    lasted = m_el + 1;
    pend   = PED_EN && m_pend;
    case (m_phase)
      0: if (lasted >= MIN_GREEN && (!ta || (lasted >= MAX_GREEN && (tb || pend)))) nxt = 1;
      3: if (lasted >= MIN_GREEN && (!tb || (lasted >= MAX_GREEN && (ta || pend)))) nxt = 4;
      1: if (lasted == YELLOW) nxt = 2;
      4: if (lasted == YELLOW) nxt = 5;
      2: if (lasted == ALL_RED) nxt = pend ? 6 : 3;
      5: if (lasted == ALL_RED) nxt = pend ? 6 : 0;
      6: if (lasted == WALK) nxt = m_from_ab ? 3 : 0;
      default: nxt = 0;
    endcase
    if (PED_EN) begin
      if (pr && m_phase != 6) m_pend = 1;
      if (nxt == 6 && m_phase != 6) begin
        m_pend    = 0;
        m_from_ab = (m_phase == 2);
      end
    end
    m_el    = (nxt != m_phase) ? 0 : m_el + 1;
    m_phase = nxt;
  endtask

  // One clock cycle: drive this cycle's inputs, then settle just after the edge that samples them.
  task automatic tick(input bit rst, input bit ta, input bit tb, input bit pr);
    reset       = rst;
    bus.Ta      = ta;
    bus.Tb      = tb;
    bus.ped_req = pr;
    @(posedge clk);
    model_step(rst, ta, tb, pr);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got La/Lb/walk/phase=%b, expected %b", name, got, exp);
    end
  endtask

  function automatic logic [7:0] dut_out();
    return {bus.La, bus.Lb, bus.walk, bus.phase};
  endfunction

  typedef struct {
    bit         ta;
    bit         tb;
    int         ped_every;
    int         cyc;
    logic [1:0] la;
    logic [1:0] lb;
    logic       wk;
    logic [2:0] ph;
  } vec_t;

  vec_t vecs[20];
  int   nvec;

  initial begin
    // Timing checkpoints taken from the phase rules; cycle 0 is the first cycle after reset.
    vecs[0]  = '{1, 1, 0, 0,  G, R, 0, 3'd0};
    vecs[1]  = '{1, 1, 0, 31, G, R, 0, 3'd0};
    vecs[2]  = '{1, 1, 0, 32, Y, R, 0, 3'd1};
    vecs[3]  = '{1, 1, 0, 34, Y, R, 0, 3'd1};
    vecs[4]  = '{1, 1, 0, 35, R, R, 0, 3'd2};
    vecs[5]  = '{1, 1, 0, 36, R, G, 0, 3'd3};
    vecs[6]  = '{0, 1, 0, 7,  G, R, 0, 3'd0};
    vecs[7]  = '{0, 1, 0, 8,  Y, R, 0, 3'd1};
    vecs[8]  = '{0, 1, 0, 10, Y, R, 0, 3'd1};
    vecs[9]  = '{0, 1, 0, 11, R, R, 0, 3'd2};
    vecs[10] = '{0, 1, 0, 12, R, G, 0, 3'd3};
    vecs[11] = '{1, 0, 0, 99, G, R, 0, 3'd0};
    vecs[12] = '{1, 0, 0, 50, G, R, 0, 3'd0};
    nvec = 13;
`ifndef TL_PED_EN
    // Pedestrian pulses must change nothing when the walk feature is absent.
    vecs[13] = '{0, 1, 5, 7,  G, R, 0, 3'd0};
    vecs[14] = '{0, 1, 5, 8,  Y, R, 0, 3'd1};
    vecs[15] = '{0, 1, 5, 11, R, R, 0, 3'd2};
    vecs[16] = '{0, 1, 5, 12, R, G, 0, 3'd3};
    vecs[17] = '{0, 1, 5, 25, R, G, 0, 3'd3};
    nvec = 18;
`endif

    bus.Ta = 0; bus.Tb = 0; bus.ped_req = 0; reset = 1;

    for (int v = 0; v < nvec; v++) begin
      tick(1, 0, 0, 0);
      if (v == 0) check("reset_state", dut_out(), {G, R, 1'b0, 3'd0});
      for (int c = 0; c < vecs[v].cyc; c++)
        tick(0, vecs[v].ta, vecs[v].tb,
             (vecs[v].ped_every != 0) && (c % vecs[v].ped_every == 0));
      check($sformatf("vec%0d_cyc%0d", v, vecs[v].cyc), dut_out(),
            {vecs[v].la, vecs[v].lb, vecs[v].wk, vecs[v].ph});
    end

    // Reset during B_YEL returns to A green, which then lasts the minimum time.
    tick(1, 0, 0, 0);
    for (int c = 0; c < 12; c++) tick(0, 0, 1, 0);
    for (int c = 12; c < 21; c++) tick(0, 1, 0, 0);
    check("b_yel_before_reset", dut_out(), {R, Y, 1'b0, 3'd4});
    tick(1, 0, 1, 0);
    check("reset_mid_b_yel", dut_out(), {G, R, 1'b0, 3'd0});
    for (int c = 1; c < MIN_GREEN; c++) begin
      tick(0, 0, 1, 0);
      check($sformatf("min_green_after_reset_%0d", c), dut_out(), {G, R, 1'b0, 3'd0});
    end
    tick(0, 0, 1, 0);
    check("yellow_after_min_green", dut_out(), {Y, R, 1'b0, 3'd1});

`ifdef TL_PED_EN
    // Pedestrian pulse at cycle 2: walk in cycles 12-17, then B green.
    tick(1, 0, 0, 0);
    for (int c = 0; c < 19; c++) begin
      tick(0, 0, 1, (c == 2));
      if (c + 1 >= 12 && c + 1 <= 17)
        check($sformatf("ped_walk_cyc%0d", c + 1), dut_out(), {R, R, 1'b1, 3'd6});
      else if (c + 1 == 18)
        check("ped_then_b_green", dut_out(), {R, G, 1'b0, 3'd3});
    end
`endif

    // Randomized traffic against the reference model.
    tick(1, 0, 0, 0);
    for (int blk = 0; blk < 15; blk++) begin
      int pa, pb;
      pa = $urandom_range(10, 95);
      pb = $urandom_range(10, 95);
      for (int c = 0; c < 200; c++) begin
        bit ta, tb, pr, rst;
        ta  = ($urandom_range(0, 99) < pa);
        tb  = ($urandom_range(0, 99) < pb);
        pr  = ($urandom_range(0, 24) == 0);
        rst = ($urandom_range(0, 399) == 0);
        tick(rst, ta, tb, pr);
        check($sformatf("random_b%0d_c%0d", blk, c), dut_out(), model_out());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tl_phase_sched.md
# tl_phase_sched

Timed phase scheduler for the two-street intersection light controller. It sequences the A/B lights through green, yellow and all-red clearance phases, using per-phase cycle counters instead of raw sensor-to-state stepping. It enforces a minimum and a maximum green time and, optionally, serves a pedestrian walk phase. It sits above the light output decoding and drives `La`/`Lb` directly.

## Interface
- `MIN_GREEN`, 8: minimum green duration in cycles (≥1).
- `MAX_GREEN`, 32: green length after which pending cross demand forces a change (≥`MIN_GREEN`).
- `YELLOW`, 3: yellow duration in cycles (≥1).
- `ALL_RED`, 1: all-red clearance in cycles (≥1).
- `WALK`, 6: pedestrian walk duration in cycles (≥1).
- `CNT_W`, 6: phase counter width; every duration must be ≤ 2^`CNT_W`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `Ta` in 1: traffic present on street A.
- `Tb` in 1: traffic present on street B.
- `ped_req` in 1: pedestrian request; a one-cycle pulse is sufficient.
- `La` out 2: street A light. Encoding: GREEN=2'b00, YELLOW=2'b01, RED=2'b10.
- `Lb` out 2: street B light, same encoding as `La`.
- `walk` out 1: pedestrian walk signal.
- `phase` out 3: current state code, for debug.

## Operation
- States and codes: A_GRN=0, A_YEL=1, RED_AB=2, B_GRN=3, B_YEL=4, RED_BA=5, PED=6.
- `cnt` holds the cycles already spent in the current state.
  - It clears to 0 on every state transition.
  - Otherwise it increments, saturating at `MAX_GREEN`-1.
- A_GRN → A_YEL when `cnt` ≥ `MIN_GREEN`-1 and either:
  - `Ta`=0, or
  - `cnt`=`MAX_GREEN`-1 and (`Tb` | `ped_pending`).
  - Otherwise the state holds.
- B_GRN → B_YEL under the same rule, with `Ta`/`Tb` swapped.
- A_YEL → RED_AB and B_YEL → RED_BA when `cnt`=`YELLOW`-1.
- Clearance exits when `cnt`=`ALL_RED`-1:
  - RED_AB → PED if `ped_pending`, else → B_GRN.
  - RED_BA → PED if `ped_pending`, else → A_GRN.
- PED → B_GRN if entered from RED_AB, or → A_GRN if entered from RED_BA, when `cnt`=`WALK`-1.
  - A 1-bit `ped_from_ab` register records which clearance PED was entered from.
- `ped_pending` (registered):
  - Set in any cycle `ped_req`=1 while not in PED.
  - Cleared on the transition into PED.
  - `ped_req` is ignored while in PED.
- Outputs are decoded from the state register (Moore, no combinational input path):
  - A_GRN: La=GREEN, Lb=RED.
  - A_YEL: La=YELLOW, Lb=RED.
  - B_GRN: La=RED, Lb=GREEN.
  - B_YEL: La=RED, Lb=YELLOW.
  - RED_AB, RED_BA, PED: both RED.
  - `walk`=1 only in PED.
- Any unused state code recovers to A_GRN on the next clock.

## Timing
- Reset (synchronous, sampled on a rising edge) gives:
  - state=A_GRN, `cnt`=0, `ped_pending`=0, `ped_from_ab`=0.
  - La=GREEN, Lb=RED, `walk`=0, `phase`=0.
- Reset asserted mid-phase overrides every transition and takes effect on that edge.
- Phase durations:
  - Yellow, all-red and walk states each last exactly their parameter in cycles.
  - Green lasts ≥`MIN_GREEN` cycles, and ≤`MAX_GREEN` cycles when cross demand exists.
- Inputs are sampled on the edge that ends a cycle. The output change appears in the next cycle, a one-cycle latency.
- With `Ta`=1 and no cross demand, green holds indefinitely; `cnt` stays saturated.
- `ped_req` arriving in the same cycle as a clearance exit is not served at that exit. It is served at the next clearance.

## Configuration
- `TL_PED_EN` defined:
  - PED state, `ped_pending` and `ped_from_ab` are implemented.
  - `ped_pending` contributes to the max-green rule.
- `TL_PED_EN` undefined:
  - `ped_req` is ignored, `walk` is tied to 0 and PED is unreachable.
  - Clearance always exits directly to the opposite green.
  - Port list is unchanged.

## Test plan
- Reset, then `Ta`=1, `Tb`=1 held → A_GRN cycles 0–31, A_YEL cycles 32–34, RED_AB cycle 35, B_GRN from cycle 36.
- Reset, then `Ta`=0, `Tb`=1 → La=GREEN cycles 0–7, YELLOW 8–10, both RED 11, Lb=GREEN from 12.
- Reset, then `Ta`=1, `Tb`=0 for 100 cycles → La=GREEN and Lb=RED throughout; `phase`=0.
- `TL_PED_EN` defined, `Ta`=0, `Tb`=1, `ped_req` pulse at cycle 2 → `walk`=1 cycles 12–17 with both lights RED; Lb=GREEN from 18.
- Assert `reset` for one cycle during B_YEL → next cycle La=GREEN, Lb=RED, `walk`=0, `phase`=0; A green then lasts ≥8 cycles.
- `TL_PED_EN` undefined, `ped_req` pulsed every 5 cycles, same stimulus as the second scenario → `walk` always 0; identical light timing to the second scenario.
